// File: rtl/dsm2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dsm2_pkg
// Purpose  : Shared constants for the second-order delta-sigma modulator.
// Revision : 1.0 - initial release
// ============================================================================
package dsm2_pkg;

    localparam int DATA_WIDTH_DEF = 14;
    localparam int MON_WIDTH      = 25;

    localparam logic [3:0] MON_I1     = 4'd0;
    localparam logic [3:0] MON_I2     = 4'd1;
    localparam logic [3:0] MON_HOLD   = 4'd2;
    localparam logic [3:0] MON_PHASE  = 4'd3;
    localparam logic [3:0] MON_STATUS = 4'd4;
    localparam logic [3:0] MON_ONES   = 4'd5;

    localparam int STAT_UNDERRUN = 0;
    localparam int STAT_SAT1     = 1;
    localparam int STAT_SAT2     = 2;

endpackage
`default_nettype wire

// File: rtl/dsm2_integrator.sv
`default_nettype none
// ============================================================================
// Module   : dsm2_integrator
// Purpose  : Signed saturating sum of an accumulator and two terms.
// Revision : 1.0 - initial release
// ============================================================================
module dsm2_integrator #(
    parameter int WIDTH = 17
) (
    input  logic signed [WIDTH-1:0] i_acc,
    input  logic signed [WIDTH-1:0] i_term_a,
    input  logic signed [WIDTH-1:0] i_term_b,
    output logic signed [WIDTH-1:0] o_sum,
    output logic                    o_sat
);
    // Two guard bits hold any sum of three WIDTH-bit operands exactly.
    localparam logic signed [WIDTH+1:0] c_max = {3'b000, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH+1:0] c_min = {3'b111, {(WIDTH-1){1'b0}}};

    logic signed [WIDTH+1:0] w_full;

    assign w_full = {{2{i_acc[WIDTH-1]}}, i_acc}
                  + {{2{i_term_a[WIDTH-1]}}, i_term_a}
                  + {{2{i_term_b[WIDTH-1]}}, i_term_b};

    always_comb begin
        o_sum = w_full[WIDTH-1:0];
        o_sat = 1'b0;
        if (w_full > c_max) begin
            o_sum = c_max[WIDTH-1:0];
            o_sat = 1'b1;
        end else if (w_full < c_min) begin
            o_sum = c_min[WIDTH-1:0];
            o_sat = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dsm2_echip65.sv
`default_nettype none
// ============================================================================
// Module   : dsm2_echip65
// Purpose  : Second-order delta-sigma modulator, zero-order-hold input,
//            1-bit output stream and selectable digital monitor.
// Revision : 1.0 - initial release
// ============================================================================
module dsm2_echip65
    import dsm2_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int OSR        = 32,
    parameter int I1_WIDTH   = DATA_WIDTH + 3,
    parameter int I2_WIDTH   = DATA_WIDTH + 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  out,
    input  logic                  clear_status,
    input  logic [3:0]            digital_monitor_sel,
    output logic [MON_WIDTH-1:0]  digital_monitor
);
    localparam int                         c_phase_w    = $clog2(OSR);
    localparam logic [c_phase_w-1:0]       c_phase_last = c_phase_w'(OSR - 1);
    localparam logic [c_phase_w-1:0]       c_phase_one  = c_phase_w'(1);
    localparam logic signed [DATA_WIDTH:0] c_half       = {2'b01, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [DATA_WIDTH:0] c_neg_half   = {2'b11, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0]      c_hold_rst   = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic [c_phase_w-1:0]       r_phase;
    logic signed [I1_WIDTH-1:0] r_i1;
    logic signed [I2_WIDTH-1:0] r_i2;
    logic [DATA_WIDTH-1:0]      r_hold;
    logic                       r_out;
    logic                       r_underrun;
    logic                       r_sat1;
    logic                       r_sat2;
    logic [MON_WIDTH-1:0]       r_ones;
    logic [MON_WIDTH-1:0]       r_mon;

    logic                       w_last;
    logic signed [DATA_WIDTH:0] w_u;
    logic signed [DATA_WIDTH:0] w_neg_y;
    logic signed [I1_WIDTH-1:0] w_u_i1;
    logic signed [I1_WIDTH-1:0] w_neg_y_i1;
    logic signed [I2_WIDTH-1:0] w_i1_i2;
    logic signed [I2_WIDTH-1:0] w_neg_y_i2;
    logic signed [I1_WIDTH-1:0] w_i1_next;
    logic signed [I2_WIDTH-1:0] w_i2_next;
    logic                       w_sat1;
    logic                       w_sat2;
    logic [2:0]                 w_status;
    logic [MON_WIDTH-1:0]       w_mon;

    assign w_last   = (r_phase == c_phase_last);
    assign in_ready = en & w_last;
    assign out      = r_out;

    // Offset-binary sample to signed error around mid-scale; feedback is +/-H.
    assign w_u     = $signed({1'b0, r_hold}) - c_half;
    assign w_neg_y = r_out ? c_neg_half : c_half;

    assign w_u_i1     = {{(I1_WIDTH-DATA_WIDTH-1){w_u[DATA_WIDTH]}}, w_u};
    assign w_neg_y_i1 = {{(I1_WIDTH-DATA_WIDTH-1){w_neg_y[DATA_WIDTH]}}, w_neg_y};
    assign w_i1_i2    = {{(I2_WIDTH-I1_WIDTH){r_i1[I1_WIDTH-1]}}, r_i1};
    assign w_neg_y_i2 = {{(I2_WIDTH-DATA_WIDTH-1){w_neg_y[DATA_WIDTH]}}, w_neg_y};

    dsm2_integrator #(.WIDTH(I1_WIDTH)) u_int1 (
        .i_acc    (r_i1),
        .i_term_a (w_u_i1),
        .i_term_b (w_neg_y_i1),
        .o_sum    (w_i1_next),
        .o_sat    (w_sat1)
    );

    dsm2_integrator #(.WIDTH(I2_WIDTH)) u_int2 (
        .i_acc    (r_i2),
        .i_term_a (w_i1_i2),
        .i_term_b (w_neg_y_i2),
        .o_sum    (w_i2_next),
        .o_sat    (w_sat2)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_phase    <= '0;
            r_i1       <= '0;
            r_i2       <= '0;
            r_hold     <= c_hold_rst;
            r_out      <= 1'b0;
            r_ones     <= '0;
            r_underrun <= 1'b0;
            r_sat1     <= 1'b0;
            r_sat2     <= 1'b0;
        end else begin
            // A new event in the clearing cycle still sets its flag.
            r_underrun <= (r_underrun & ~clear_status) | (in_ready & ~in_valid);
            r_sat1     <= (r_sat1 & ~clear_status) | (en & w_sat1);
            r_sat2     <= (r_sat2 & ~clear_status) | (en & w_sat2);
            if (!en) begin
                r_phase <= '0;
                r_i1    <= '0;
                r_i2    <= '0;
                r_out   <= 1'b0;
                r_ones  <= '0;
            end else begin
                r_phase <= w_last ? '0 : r_phase + c_phase_one;
                r_i1    <= w_i1_next;
                r_i2    <= w_i2_next;
                r_out   <= ~w_i2_next[I2_WIDTH-1];
                r_ones  <= r_ones + {{(MON_WIDTH-1){1'b0}}, r_out};
                if (in_ready && in_valid) begin
                    r_hold <= in_data;
                end
            end
        end
    end

    always_comb begin
        w_status                = '0;
        w_status[STAT_UNDERRUN] = r_underrun;
        w_status[STAT_SAT1]     = r_sat1;
        w_status[STAT_SAT2]     = r_sat2;
    end

    always_comb begin
        w_mon = '0;
        case (digital_monitor_sel)
            MON_I1:     w_mon = {{(MON_WIDTH-I1_WIDTH){r_i1[I1_WIDTH-1]}}, r_i1};
            MON_I2:     w_mon = {{(MON_WIDTH-I2_WIDTH){r_i2[I2_WIDTH-1]}}, r_i2};
            MON_HOLD:   w_mon = {{(MON_WIDTH-DATA_WIDTH){1'b0}}, r_hold};
            MON_PHASE:  w_mon = {{(MON_WIDTH-c_phase_w){1'b0}}, r_phase};
            MON_STATUS: w_mon = {{(MON_WIDTH-3){1'b0}}, w_status};
            MON_ONES:   w_mon = r_ones;
            default:    w_mon = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mon <= '0;
        end else begin
            r_mon <= w_mon;
        end
    end

    assign digital_monitor = r_mon;

endmodule
`default_nettype wire

// File: tb/tb_dsm2_echip65.sv
`default_nettype none
// ============================================================================
// Module   : tb_dsm2_echip65
// Purpose  : Directed and randomized checks of dsm2_echip65 against an
//            integer reference model of the modulator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dsm2_echip65;
    localparam int DW  = 14;
    localparam int OSR = 32;
    localparam int H   = 8192;

    logic        clk;
    logic        reset;
    logic        en;
    logic [13:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        out;
    logic        clear_status;
    logic [3:0]  digital_monitor_sel;
    logic [24:0] digital_monitor;

    int n_vec = 0;
    int n_err = 0;
    int ones_seen = 0;

    // Reference model state
    int          m_i1, m_i2, m_hold, m_phase;
    bit          m_out;
    bit   [2:0]  m_flags;
    int unsigned m_ones;
    logic [24:0] m_mon;

    bit pat [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    dsm2_echip65 #(.DATA_WIDTH(DW), .OSR(OSR)) dut (
        .clk                 (clk),
        .reset               (reset),
        .en                  (en),
        .in_data             (in_data),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .out                 (out),
        .clear_status        (clear_status),
        .digital_monitor_sel (digital_monitor_sel),
        .digital_monitor     (digital_monitor)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int clamp(input int v, input int w);
        int hi = (1 << (w - 1)) - 1;
        int lo = -(1 << (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    task automatic check(input string tag, input logic [24:0] obs, input logic [24:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_i1 = 0; m_i2 = 0; m_hold = H; m_phase = 0;
        m_out = 1'b0; m_flags = 3'b000; m_ones = 0; m_mon = '0;
    endtask

    // One clock of the modulator rules, computed with plain integers.
    task automatic m_step(input bit e, input bit v, input int d, input bit c, input int s);
        logic [24:0] mon_n;
        bit   [2:0]  ev;
        int u, y, t1, t2, n1, n2;
        case (s)
            0:       mon_n = 25'(m_i1);
            1:       mon_n = 25'(m_i2);
            2:       mon_n = 25'(m_hold);
            3:       mon_n = 25'(m_phase);
            4:       mon_n = {22'b0, m_flags};
            5:       mon_n = 25'(m_ones);
            default: mon_n = '0;
        endcase
        ev = 3'b000;
        if (e) begin
            u  = m_hold - H;
            y  = m_out ? H : -H;
            t1 = m_i1 + u - y;
            n1 = clamp(t1, DW + 3);
            t2 = m_i2 + m_i1 - y;
            n2 = clamp(t2, DW + 5);
            if (n1 != t1) ev[1] = 1'b1;
            if (n2 != t2) ev[2] = 1'b1;
            if (m_phase == OSR - 1) begin
                if (v) m_hold = d;
                else   ev[0] = 1'b1;
            end
            m_ones  = (m_ones + (m_out ? 1 : 0)) & 32'h01FF_FFFF;
            m_out   = (n2 >= 0);
            m_i1    = n1;
            m_i2    = n2;
            m_phase = (m_phase + 1) % OSR;
        end else begin
            m_i1 = 0; m_i2 = 0; m_phase = 0; m_out = 1'b0; m_ones = 0;
        end
        m_flags = (m_flags & ~{3{c}}) | ev;
        m_mon   = mon_n;
    endtask

    // Called at posedge+1; returns at the following posedge+1.
    task automatic cycle(input bit e, input bit v, input int d, input bit c, input int s);
        en                  = e;
        in_valid            = v;
        in_data             = d[13:0];
        clear_status        = c;
        digital_monitor_sel = s[3:0];
        #1;
        check("in_ready", {24'b0, in_ready}, {24'b0, (e && m_phase == OSR - 1)});
        m_step(e, v, d, c, s);
        @(posedge clk);
        #1;
        check("out", {24'b0, out}, {24'b0, m_out});
        check("monitor", digital_monitor, m_mon);
        check("no_x", 25'($isunknown({out, in_ready, digital_monitor})), 25'd0);
        if (out === 1'b1) ones_seen++;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; in_valid = 1'b0; in_data = '0;
        clear_status = 1'b0; digital_monitor_sel = 4'd0;
        m_reset();
        @(posedge clk); #1;
        check("rst_out", {24'b0, out}, 25'd0);
        check("rst_ready", {24'b0, in_ready}, 25'd0);
        check("rst_mon", digital_monitor, 25'd0);
        @(negedge clk);
        reset = 1'b0;
        m_step(0, 0, 0, 0, 0);
        @(posedge clk); #1;

        // Mid-scale: fixed start pattern and 50 % density
        ones_seen = 0;
        for (int k = 0; k < 8; k++) begin
            cycle(1, 1, 8192, 0, 5);
            check("pattern_mid", {24'b0, out}, {24'b0, pat[k]});
        end
        for (int k = 8; k < 1024; k++) cycle(1, 1, 8192, 0, 5);
        check("ones_mid", 25'(ones_seen >= 508 && ones_seen <= 516), 25'd1);
        check("mon_ones_mid", 25'(digital_monitor >= 508 && digital_monitor <= 516), 25'd1);

        // 0.75 full scale
        cycle(0, 0, 0, 0, 5);
        ones_seen = 0;
        for (int k = 0; k < 4096; k++) cycle(1, 1, 12288, 0, 5);
        check("ones_3q", 25'(ones_seen >= 3064 && ones_seen <= 3080), 25'd1);
        cycle(1, 1, 12288, 0, 4);
        check("status_3q", digital_monitor, 25'd0);

        // Underrun: valid low across one ready cycle
        for (int k = 0; k < OSR; k++) cycle(1, 0, int'($urandom_range(0, 16383)), 0, 0);
        cycle(1, 1, 12288, 0, 2);
        check("hold_kept", digital_monitor, 25'd12288);
        cycle(1, 1, 12288, 0, 4);
        check("underrun", digital_monitor, 25'd1);
        cycle(1, 1, 12288, 1, 4);
        cycle(1, 1, 12288, 0, 4);
        check("cleared", digital_monitor, 25'd0);

        // Full scale: load hold first, then restart
        for (int k = 0; k < OSR; k++) cycle(1, 1, 16383, 0, 4);
        cycle(0, 1, 16383, 0, 4);
        ones_seen = 0;
        for (int k = 0; k < 2000; k++) cycle(1, 1, 16383, 0, 4);
        check("ones_fs", 25'(ones_seen >= 1990), 25'd1);
        check("sat_fs", 25'((digital_monitor & 25'd6) != 0), 25'd1);

        // en drop mid-sample, then restart with mid-scale hold
        for (int k = 0; k < OSR; k++) cycle(1, 1, 8192, 1, 2);
        cycle(0, 1, 8192, 0, 0);
        for (int k = 0; k < 10; k++) cycle(1, 1, 8192, 0, 3);
        check("phase10", digital_monitor, 25'd9);
        cycle(0, 1, 8192, 0, 0);
        check("en0_out", {24'b0, out}, 25'd0);
        cycle(0, 1, 8192, 0, 0);
        check("en0_i1", digital_monitor, 25'd0);
        cycle(0, 1, 8192, 0, 1);
        check("en0_i2", digital_monitor, 25'd0);
        cycle(0, 1, 8192, 0, 3);
        check("en0_phase", digital_monitor, 25'd0);
        for (int k = 0; k < 8; k++) begin
            cycle(1, 1, 8192, 0, 5);
            check("pattern_restart", {24'b0, out}, {24'b0, pat[k]});
        end

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            cycle(($urandom_range(0, 49) != 0), ($urandom_range(0, 9) < 7),
                  int'($urandom_range(0, 16383)), ($urandom_range(0, 19) == 0),
                  int'($urandom_range(0, 15)));
        end

        // Asynchronous reset between edges
        for (int k = 0; k < 5; k++) cycle(1, 1, 8192, 0, 2);
        #3;
        reset = 1'b1;
        #1;
        check("async_out", {24'b0, out}, 25'd0);
        check("async_ready", {24'b0, in_ready}, 25'd0);
        check("async_mon", digital_monitor, 25'd0);
        m_reset();
        en = 1'b0;
        digital_monitor_sel = 4'd0;
        @(negedge clk);
        reset = 1'b0;
        m_step(0, 0, 0, 0, 0);
        @(posedge clk); #1;
        check("post_rst_out", {24'b0, out}, {24'b0, m_out});
        check("post_rst_mon", digital_monitor, m_mon);
        for (int k = 0; k < 8; k++) begin
            cycle(1, 1, 8192, 0, 2);
            check("pattern_post_rst", {24'b0, out}, {24'b0, pat[k]});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
